// File: rtl/fcmp_arbiter.sv
// Round-robin arbiter sharing one pipelined FP compare unit among NREQ requesters.
// Each accepted op is registered onto the unit and its owner rides a tag pipe to the response.
module fcmp_arbiter #(
    parameter int NREQ = 2,
    parameter int LAT  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [32*NREQ-1:0]   req_x1,
    input  logic [32*NREQ-1:0]   req_x2,
    input  logic [2*NREQ-1:0]    req_op,
    output logic [NREQ-1:0]      req_ready,
    output logic                 cmp_valid,
    output logic [31:0]          cmp_x1,
    output logic [31:0]          cmp_x2,
    output logic [1:0]           cmp_op,
    input  logic                 cmp_y,
    output logic [NREQ-1:0]      resp_valid,
    output logic                 resp_y,
    output logic                 busy
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    // Handshake: an op is accepted on a rising edge where req_valid[i] & req_ready[i];
    // req_ready never waits on the unit, so a granted requester is always taken.
    logic [IW-1:0]   r_ptr;
    logic [IW-1:0]   r_owner;
    logic            r_cmp_valid;
    logic [31:0]     r_cmp_x1;
    logic [31:0]     r_cmp_x2;
    logic [1:0]      r_cmp_op;
    logic [LAT-1:0]  r_tag_v;
    logic [IW-1:0]   r_tag_id [LAT];

    logic            w_any;
    logic [IW-1:0]   w_gidx;
    logic [IW-1:0]   w_cand;
    logic [IW-1:0]   w_ptr_nxt;
    logic [NREQ-1:0] w_grant;
    logic [31:0]     w_x1;
    logic [31:0]     w_x2;
    logic [1:0]      w_op;

    always_comb begin
        w_any   = 1'b0;
        w_gidx  = '0;
        w_cand  = '0;
        w_grant = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_cand = IW'((int'(r_ptr) + k) % NREQ);
            if (!w_any && req_valid[w_cand]) begin
                w_any  = 1'b1;
                w_gidx = w_cand;
            end
        end
        if (w_any) begin
            w_grant[w_gidx] = 1'b1;
        end
        w_ptr_nxt = (w_gidx == IW'(NREQ - 1)) ? '0 : w_gidx + 1'b1;
    end

    // One-hot AND-OR mux of the winner's operands.
    always_comb begin
        w_x1 = '0;
        w_x2 = '0;
        w_op = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (w_grant[k]) begin
                w_x1 = req_x1[32*k +: 32];
                w_x2 = req_x2[32*k +: 32];
                w_op = req_op[2*k +: 2];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr       <= '0;
            r_owner     <= '0;
            r_cmp_valid <= 1'b0;
            r_cmp_x1    <= '0;
            r_cmp_x2    <= '0;
            r_cmp_op    <= '0;
            r_tag_v     <= '0;
            for (int s = 0; s < LAT; s++) begin
                r_tag_id[s] <= '0;
            end
        end else begin
            r_cmp_valid <= w_any;
            if (w_any) begin
                r_ptr    <= w_ptr_nxt;
                r_owner  <= w_gidx;
                r_cmp_x1 <= w_x1;
                r_cmp_x2 <= w_x2;
                r_cmp_op <= w_op;
            end
            // Stage 0 follows the cycle the unit samples cmp_valid, so stage LAT-1 meets cmp_y.
            r_tag_v[0]  <= r_cmp_valid;
            r_tag_id[0] <= r_owner;
            for (int s = 1; s < LAT; s++) begin
                r_tag_v[s]  <= r_tag_v[s-1];
                r_tag_id[s] <= r_tag_id[s-1];
            end
        end
    end

    always_comb begin
        resp_valid = '0;
        if (r_tag_v[LAT-1]) begin
            resp_valid[r_tag_id[LAT-1]] = 1'b1;
        end
    end

    assign req_ready = w_grant;
    assign cmp_valid = r_cmp_valid;
    assign cmp_x1    = r_cmp_x1;
    assign cmp_x2    = r_cmp_x2;
    assign cmp_op    = r_cmp_op;
    assign resp_y    = cmp_y;
    assign busy      = r_cmp_valid | (|r_tag_v);
endmodule

// File: tb/tb_fcmp_arbiter.sv
// Bench for fcmp_arbiter: emulates the compare unit, predicts grants/responses with a
// round-robin reference model and checks them through a queue-based scoreboard.
module tb_fcmp_arbiter;
    localparam int NREQ = 3;
    localparam int LAT  = 3;
    localparam int W    = 32 + NREQ + 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [NREQ-1:0]    req_valid = '0;
    logic [32*NREQ-1:0] req_x1 = '0;
    logic [32*NREQ-1:0] req_x2 = '0;
    logic [2*NREQ-1:0]  req_op = '0;
    logic [NREQ-1:0]    req_ready;
    logic               cmp_valid;
    logic [31:0]        cmp_x1;
    logic [31:0]        cmp_x2;
    logic [1:0]         cmp_op;
    logic               cmp_y;
    logic [NREQ-1:0]    resp_valid;
    logic               resp_y;
    logic               busy;

    fcmp_arbiter #(.NREQ(NREQ), .LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_x1(req_x1), .req_x2(req_x2), .req_op(req_op),
        .req_ready(req_ready),
        .cmp_valid(cmp_valid), .cmp_x1(cmp_x1), .cmp_x2(cmp_x2), .cmp_op(cmp_op),
        .cmp_y(cmp_y),
        .resp_valid(resp_valid), .resp_y(resp_y), .busy(busy)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference IEEE-754 compare ----------------
    function automatic logic fcmp_ref(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
        logic a_nan, b_nan, eq, lt;
        a_nan = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
        b_nan = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
        eq = (a == b) || ((a[30:0] == 31'd0) && (b[30:0] == 31'd0));
        if (a[31] != b[31]) lt = a[31] && !eq;
        else if (!a[31])    lt = a[30:0] < b[30:0];
        else                lt = a[30:0] > b[30:0];
        if (a_nan || b_nan) return 1'b0;
        case (op)
            2'b00:   return eq;
            2'b01:   return lt;
            2'b10:   return lt || eq;
            default: return 1'b0;
        endcase
    endfunction

    // Shared unit emulation: result LAT cycles after cmp_valid is sampled, noise otherwise.
    logic [LAT-1:0] y_pipe = '0;
    always @(posedge clk) begin
        y_pipe <= {y_pipe[LAT-2:0],
                   cmp_valid ? fcmp_ref(cmp_x1, cmp_x2, cmp_op) : 1'($urandom_range(0, 1))};
    end
    assign cmp_y = y_pipe[LAT-1];

    // ---------------- scoreboard ----------------
    logic [W-1:0]  exp_q[$];
    logic [65:0]   iss_q[$];
    int            n_checks = 0;
    int            n_fail = 0;
    bit            mon_en = 1'b0;
    logic [31:0]   last_x1 = '0;
    logic [31:0]   last_x2 = '0;
    logic [1:0]    last_op = '0;
    int            model_ptr = 0;

    task automatic check(input string name, input logic [65:0] act, input logic [65:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic int rr_pick(input logic [NREQ-1:0] v);
        for (int k = 0; k < NREQ; k++) begin
            if (v[(model_ptr + k) % NREQ]) return (model_ptr + k) % NREQ;
        end
        return -1;
    endfunction

    // Monitor: samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            check("busy", 66'(busy), 66'(exp_q.size() != 0));
            if (exp_q.size() != 0 && int'(exp_q[0][W-1 -: 32]) == cyc) begin
                check("resp_valid", 66'(resp_valid), 66'(exp_q[0][NREQ:1]));
                check("resp_y", 66'(resp_y), 66'(exp_q[0][0]));
                void'(exp_q.pop_front());
            end else begin
                check("resp_idle", 66'(resp_valid), 66'(0));
            end
            if (iss_q.size() != 0) begin
                check("cmp_valid", 66'(cmp_valid), 66'(1));
                check("cmp_data", {cmp_x1, cmp_x2, cmp_op}, iss_q[0]);
                {last_x1, last_x2, last_op} = iss_q.pop_front();
            end else begin
                check("cmp_hold", {cmp_valid, cmp_x1, cmp_x2, cmp_op}, {1'b0, last_x1, last_x2, last_op});
            end
        end
    end

    // ---------------- driver ----------------
    logic [31:0] drv_x1 [NREQ];
    logic [31:0] drv_x2 [NREQ];
    logic [1:0]  drv_op [NREQ];
    logic [31:0] pool [8] = '{32'h3F800000, 32'h40000000, 32'hBF800000, 32'h00000000,
                              32'h80000000, 32'h7FC00000, 32'h7F800000, 32'h3F800001};

    task automatic step(input logic [NREQ-1:0] v);
        int w;
        logic [NREQ-1:0] oh;
        @(negedge clk);
        #2;
        req_valid = v;
        for (int i = 0; i < NREQ; i++) begin
            req_x1[32*i +: 32] = drv_x1[i];
            req_x2[32*i +: 32] = drv_x2[i];
            req_op[2*i +: 2]   = drv_op[i];
        end
        #1;
        w  = rr_pick(v);
        oh = '0;
        if (w >= 0) oh[w] = 1'b1;
        check("req_ready", 66'(req_ready), 66'(oh));
        if (w >= 0) begin
            exp_q.push_back({32'(cyc + 1 + LAT), oh, fcmp_ref(drv_x1[w], drv_x2[w], drv_op[w])});
            iss_q.push_back({drv_x1[w], drv_x2[w], drv_op[w]});
            model_ptr = (w + 1) % NREQ;
        end
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
        drv_x1[i] = a;
        drv_x2[i] = b;
        drv_op[i] = op;
    endtask

    task automatic reset_now();
        @(negedge clk);
        #2;
        req_valid = '0;
        rst = 1'b1;
        #1;
        check("rst_cmp", {cmp_valid, cmp_x1, cmp_x2, cmp_op}, 66'(0));
        check("rst_resp", 66'({resp_valid, busy, req_ready}), 66'(0));
        exp_q.delete();
        iss_q.delete();
        model_ptr = 0;
        last_x1 = '0;
        last_x2 = '0;
        last_op = '0;
        repeat (2) @(negedge clk);
        #2;
        rst = 1'b0;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        for (int i = 0; i < NREQ; i++) set_req(i, 32'h0, 32'h0, 2'b00);
        #1;
        check("reset_cmp", {cmp_valid, cmp_x1, cmp_x2, cmp_op}, 66'(0));
        check("reset_out", 66'({resp_valid, busy}), 66'(0));
        repeat (2) @(negedge clk);
        #2;
        rst = 1'b0;
        mon_en = 1'b1;

        // single feq 1.0 == 1.0 from requester 0
        set_req(0, 32'h3F800000, 32'h3F800000, 2'b00);
        step(3'b001);
        repeat (LAT + 3) step('0);

        // round robin with everyone holding valid, then two holding valid
        for (int i = 0; i < NREQ; i++) set_req(i, pool[i], pool[i+1], 2'(i));
        repeat (6) step(3'b111);
        repeat (4) step(3'b011);
        repeat (LAT + 2) step('0);

        // NaN feq on requester 1
        set_req(1, 32'h7FC00000, 32'h7FC00000, 2'b00);
        step(3'b010);
        repeat (LAT + 2) step('0);

        // flt ordering, back to back
        set_req(0, 32'h3F800000, 32'h40000000, 2'b01);
        step(3'b001);
        set_req(1, 32'h40000000, 32'h3F800000, 2'b01);
        step(3'b010);
        repeat (LAT + 2) step('0);

        // reset with an op in flight, then idle with unit noise, then pointer back at 0
        set_req(2, 32'h3F800000, 32'h3F800000, 2'b10);
        step(3'b100);
        step('0);
        reset_now();
        repeat (5) step('0);
        step(3'b111);
        repeat (10) step('0);

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                set_req(i, pool[$urandom_range(0, 7)], pool[$urandom_range(0, 7)], 2'($urandom_range(0, 3)));
            end
            step(NREQ'($urandom_range(0, (1 << NREQ) - 1)));
        end

        for (int i = 0; i < 40 && exp_q.size() != 0; i++) step('0);
        check("drain_empty", 66'(exp_q.size()), 66'(0));
        step('0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fcmp_arbiter.md
Name: fcmp_arbiter

Overview:
- Shares one pipelined FPU compare unit (feq/flt/fle) between NREQ requesters, e.g. the integer pipeline and the FPU issue stage.
- Accepts at most one compare per cycle using a round-robin grant.
- Registers operands onto the shared unit and tracks each op's owner through a LAT-deep tag pipe.
- Routes each returning result as a one-cycle response pulse to the requester that issued it.

Parameters:
- NREQ, 2, number of requesters (2..8).
- LAT, 1, fixed latency of the shared compare unit in cycles, from cmp_valid sampled to cmp_y valid (LAT >= 1).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NREQ  per-requester request valid.
- req_x1  in  32*NREQ  operand 1 of requester i, in bits [32i+31:32i].
- req_x2  in  32*NREQ  operand 2, same packing as req_x1.
- req_op  in  2*NREQ  compare op of requester i: 00 feq, 01 flt, 10 fle, 11 reserved (passed through, not interpreted).
- req_ready  out  NREQ  one-hot or zero; high when requester i is granted this cycle.
- cmp_valid  out  1  op presented to the shared unit (registered).
- cmp_x1  out  32  registered operand 1 to the shared unit.
- cmp_x2  out  32  registered operand 2 to the shared unit.
- cmp_op  out  2  registered op to the shared unit.
- cmp_y  in  1  unit result; meaningful LAT cycles after cmp_valid.
- resp_valid  out  NREQ  one-hot or zero; response pulse to requester i.
- resp_y  out  1  compare result, valid while any resp_valid bit is high.
- busy  out  1  high while any op is issued and not yet responded.

Behaviour:
- Reset: asynchronous active-high; clears everything.
  - cmp_valid=0, cmp_x1=0, cmp_x2=0, cmp_op=0.
  - Tag pipe emptied (all stage valids 0).
  - resp_valid=0, busy=0.
  - Round-robin pointer reset to 0 (requester 0 has highest priority first).
- Grant (combinational):
  - Among requesters with req_valid high, grant the first at or after pointer p, searching upward with wrap from NREQ-1 to 0.
  - req_ready is one-hot to the winner, zero if none requests.
  - req_ready never depends on the response path; there is no backpressure from the unit.
- Handshake: req_valid[i] & req_ready[i] at edge t means the op is accepted.
  - The requester may change or drop its operands after t.
  - Holding req_valid high re-requests.
- Pointer update: on acceptance from requester i, p <= (i+1) mod NREQ. No acceptance leaves p unchanged.
- Issue: at edge t the accepted operands and op are registered, so cmp_valid=1 and cmp_x1/x2/op are stable during cycle t+1. If nothing is accepted, cmp_valid=0 and data regs hold their old values.
- Tag pipe:
  - LAT stages of {valid, owner index}.
  - Stage 0 loads the issue tag together with cmp_valid and advances each cycle.
  - Stage LAT-1 aligns with cmp_y.
- Response (combinational from the last tag stage):
  - resp_valid[owner] = last-stage valid; resp_y = cmp_y.
  - Acceptance-to-response latency is exactly 1+LAT cycles.
  - Back-to-back acceptances give back-to-back responses in issue order.
- busy = cmp_valid OR any tag-stage valid.
- Fairness: a continuously requesting requester is granted within NREQ cycles.
- Simultaneous events: an acceptance and a response in the same cycle are independent; full throughput is one op per cycle.
- Reset mid-operation: in-flight ops are dropped and no resp_valid is produced for them, even if cmp_y toggles.
- Arithmetic is not done here. NaN semantics belong to the unit (feq returns 0 if either operand is NaN); resp_y is cmp_y unmodified.

Test Plan:
- Single op, LAT=1: req0 sends x1=0x3F800000, x2=0x3F800000, op=00 at t0 -> req_ready=01 at t0; cmp_valid=1 with those operands at t0+1; resp_valid=01 and resp_y=1 at t0+2; busy low from t0+3.
- Round robin, NREQ=2: both requesters hold valid for 4 cycles -> grants 0,1,0,1; responses alternate 01,10,01,10 with no gaps.
- NaN passthrough: req1 sends x1=0x7FC00000, x2=0x7FC00000, op=00 with a reference feq model -> resp_valid=10, resp_y=0.
- flt ordering, LAT=3: req0 sends 1.0 vs 2.0 (0x3F800000, 0x40000000, op=01), then req1 sends 2.0 vs 1.0 next cycle -> req0 gets resp_y=1 at t+4, req1 gets resp_y=0 at t+5.
- Reset mid-flight, LAT=3: assert rst two cycles after acceptance -> all outputs 0 immediately; no resp_valid for 5 cycles after deassert; p=0 afterwards.
- Idle/hold: no req_valid for 10 cycles -> req_ready=0, cmp_valid=0, busy=0, cmp_x1/x2 unchanged.
